// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with frame-aligned display updates.
// Writes land in a one-deep pending buffer and become visible only when slot 3 ends.
module seg_scan_driver #(
    parameter int REFRESH_DIV   = 100000,
    parameter int DEAD_CYCLES   = 16,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_value,
    input  logic [3:0]  wr_blank,
    input  logic [3:0]  wr_dp,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    slot;

    logic [15:0]   act_value;
    logic [3:0]    act_blank;
    logic [3:0]    act_dp;
    logic [15:0]   pend_value;
    logic [3:0]    pend_blank;
    logic [3:0]    pend_dp;
    logic          pend_full;

    logic          slot_tick;
    logic          frame_end;
    logic          accept;
    logic          in_dead;
    logic          anode_on;
    logic [3:0]    lead;
    logic [3:0]    eff_blank;

    assign slot_tick = (prescaler == PRE_LAST);
    assign frame_end = slot_tick && (slot == 2'd3);
    assign wr_ready  = ~pend_full;
    assign accept    = wr_valid && !pend_full;

    // Digit 0 always shows so that a zero value still displays "0".
    always_comb begin
        lead = 4'b0000;
        if (BLANK_LEADING) begin
            lead[3] = (act_value[15:12] == 4'h0);
            lead[2] = (act_value[15:8]  == 8'h00);
            lead[1] = (act_value[15:4]  == 12'h000);
        end
    end

    assign eff_blank = act_blank | lead;
    assign in_dead   = (int'(prescaler) < DEAD_CYCLES);
    assign anode_on  = !in_dead && !eff_blank[slot];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            slot      <= 2'd0;
        end else if (slot_tick) begin
            prescaler <= '0;
            slot      <= slot + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Accept and commit are mutually exclusive: accept needs an empty buffer, commit a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value  <= 16'h0000;
            act_blank  <= 4'h0;
            act_dp     <= 4'h0;
            pend_value <= 16'h0000;
            pend_blank <= 4'h0;
            pend_dp    <= 4'h0;
            pend_full  <= 1'b0;
        end else begin
            if (frame_end && pend_full) begin
                act_value <= pend_value;
                act_blank <= pend_blank;
                act_dp    <= pend_dp;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_value <= wr_value;
                pend_blank <= wr_blank;
                pend_dp    <= wr_dp;
                pend_full  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit      <= 4'h0;
            an         <= 4'b1111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            digit      <= act_value[{slot, 2'b00} +: 4];
            an         <= anode_on ? ~(4'b0001 << slot) : 4'b1111;
            dp         <= anode_on ? ~act_dp[slot] : 1'b1;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: time-indexed behavioural model, directed frame pins, random writes.
module tb_seg_scan_driver;
    localparam int R  = 8;
    localparam int D  = 2;
    localparam int FR = 4 * R;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_value = 16'h0;
    logic [3:0]  wr_blank = 4'h0;
    logic [3:0]  wr_dp = 4'h0;

    logic        wr_ready, dp, frame_tick;
    logic [3:0]  digit, an;
    logic        wr_ready_nb, dp_nb, frame_tick_nb;
    logic [3:0]  digit_nb, an_nb;

    seg_scan_driver #(.REFRESH_DIV(R), .DEAD_CYCLES(D), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_value(wr_value), .wr_blank(wr_blank), .wr_dp(wr_dp),
        .digit(digit), .an(an), .dp(dp), .frame_tick(frame_tick));

    seg_scan_driver #(.REFRESH_DIV(R), .DEAD_CYCLES(D), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready_nb),
        .wr_value(wr_value), .wr_blank(wr_blank), .wr_dp(wr_dp),
        .digit(digit_nb), .an(an_nb), .dp(dp_nb), .frame_tick(frame_tick_nb));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: cyc = clock edges since reset release = time index of the state the DUT holds.
    int          cyc = 0;
    logic [15:0] m_val = 16'h0, p_val = 16'h0;
    logic [3:0]  m_blank = 4'h0, m_dp = 4'h0, p_blank = 4'h0, p_dp = 4'h0;
    logic        m_full = 1'b0, last_acc = 1'b0;
    logic [3:0]  e_digit = 4'h0, e_an = 4'hF, e_an0 = 4'hF;
    logic        e_dp = 1'b1, e_dp0 = 1'b1, e_ft = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Returns {an[3:0], dp} for one time index, straight from the display rules.
    function automatic logic [4:0] view(input int pre, input int slot, input logic [15:0] val,
                                        input logic [3:0] blank, input logic [3:0] dpm, input bit bl);
        bit dark;
        dark = (pre < D) || blank[slot] || (bl && slot > 0 && (val >> (4 * slot)) == 16'h0);
        return dark ? 5'b11111 : {~(4'b0001 << slot), ~dpm[slot]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_val = 0; m_blank = 0; m_dp = 0; p_val = 0; p_blank = 0; p_dp = 0;
            m_full = 0; last_acc = 0;
            e_digit = 0; e_an = 4'hF; e_an0 = 4'hF; e_dp = 1; e_dp0 = 1; e_ft = 0;
        end else begin
            int pre, slot;
            bit fe;
            logic [4:0] v1, v0;
            pre  = cyc % R;
            slot = (cyc / R) % 4;
            fe   = (cyc % FR) == FR - 1;
            v1 = view(pre, slot, m_val, m_blank, m_dp, 1'b1);
            v0 = view(pre, slot, m_val, m_blank, m_dp, 1'b0);
            e_digit = 4'(m_val >> (4 * slot));
            e_an = v1[4:1]; e_dp = v1[0];
            e_an0 = v0[4:1]; e_dp0 = v0[0];
            e_ft = fe;
            last_acc = wr_valid && !m_full;
            if (fe && m_full) begin
                m_val = p_val; m_blank = p_blank; m_dp = p_dp; m_full = 0;
            end
            if (last_acc) begin
                p_val = wr_value; p_blank = wr_blank; p_dp = wr_dp; m_full = 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        chk("digit", 16'(digit), 16'(e_digit));
        chk("an", 16'(an), 16'(e_an));
        chk("dp", 16'(dp), 16'(e_dp));
        chk("frame_tick", 16'(frame_tick), 16'(e_ft));
        chk("wr_ready", 16'(wr_ready), 16'(!m_full));
        chk("nb_an", 16'(an_nb), 16'(e_an0));
        chk("nb_dp", 16'(dp_nb), 16'(e_dp0));
        chk("nb_digit", 16'(digit_nb), 16'(e_digit));
    end

    task automatic wait_cyc(input int k);
        int n = 0;
        while (cyc < k && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != k) chk("wait_cyc", 16'(cyc), 16'(k));
    endtask

    task automatic pin(input int idx, input logic [3:0] an_e, input logic [3:0] dig_e,
                       input logic dp_e, input string nm);
        wait_cyc(idx + 1);
        chk({nm, "_an"}, 16'(an), 16'(an_e));
        chk({nm, "_digit"}, 16'(digit), 16'(dig_e));
        chk({nm, "_dp"}, 16'(dp), 16'(dp_e));
    endtask

    task automatic do_write(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d,
                            output int acc_idx);
        int n = 0;
        wr_valid = 1'b1; wr_value = v; wr_blank = b; wr_dp = d;
        acc_idx = -1;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (last_acc) begin
                acc_idx = cyc - 1;
                break;
            end
        end
        if (acc_idx < 0) chk("write_timeout", 16'h0, 16'h1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        int a, b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle display after reset: only digit 0 lights, frame_tick every 32 cycles.
        pin(0, 4'hF, 4'h0, 1'b1, "s1_dead0");
        chk("s1_ready", 16'(wr_ready), 16'h1);
        pin(2, 4'hE, 4'h0, 1'b1, "s1_on");
        pin(7, 4'hE, 4'h0, 1'b1, "s1_end0");
        pin(10, 4'hF, 4'h0, 1'b1, "s1_slot1");
        pin(27, 4'hF, 4'h0, 1'b1, "s1_slot3");
        wait_cyc(32);
        chk("s1_ft32", 16'(frame_tick), 16'h1);
        wait_cyc(33);
        chk("s1_ft33", 16'(frame_tick), 16'h0);
        wait_cyc(64);
        chk("s1_ft64", 16'(frame_tick), 16'h1);

        // 0x1234 written in slot 1, visible from the next frame.
        wait_cyc(73);
        do_write(16'h1234, 4'h0, 4'h0, a);
        chk("s2_acc", 16'(a), 16'd73);
        chk("s2_ready_low", 16'(wr_ready), 16'h0);
        pin(90, 4'hF, 4'h0, 1'b1, "s2_old");
        wait_cyc(96);
        chk("s2_ready_back", 16'(wr_ready), 16'h1);
        chk("s2_ft", 16'(frame_tick), 16'h1);
        pin(99, 4'hE, 4'h4, 1'b1, "s2_d0");
        pin(107, 4'hD, 4'h3, 1'b1, "s2_d1");
        pin(115, 4'hB, 4'h2, 1'b1, "s2_d2");
        pin(123, 4'h7, 4'h1, 1'b1, "s2_d3");

        // 0x0050: digits 3,2 leading-blanked, digit 0 shows a zero.
        wait_cyc(128);
        do_write(16'h0050, 4'h0, 4'h0, a);
        chk("s3_acc", 16'(a), 16'd128);
        pin(160, 4'hF, 4'h0, 1'b1, "s3_dead");
        pin(163, 4'hE, 4'h0, 1'b1, "s3_d0");
        pin(171, 4'hD, 4'h5, 1'b1, "s3_d1");
        pin(179, 4'hF, 4'h0, 1'b1, "s3_d2");
        pin(187, 4'hF, 4'h0, 1'b1, "s3_d3");
        chk("s3_nb_an", 16'(an_nb), 16'h7);

        // Back-to-back: B held until the cycle after A commits.
        wait_cyc(192);
        do_write(16'hABCD, 4'h0, 4'h0, a);
        do_write(16'h0F0F, 4'h0, 4'h0, b);
        chk("s4_acc_a", 16'(a), 16'd192);
        chk("s4_acc_b", 16'(b), 16'd224);
        pin(227, 4'hE, 4'hD, 1'b1, "s4_a0");
        pin(251, 4'h7, 4'hA, 1'b1, "s4_a3");
        pin(259, 4'hE, 4'hF, 1'b1, "s4_b0");
        pin(267, 4'hD, 4'h0, 1'b1, "s4_b1");
        pin(275, 4'hB, 4'hF, 1'b1, "s4_b2");
        pin(283, 4'hF, 4'h0, 1'b1, "s4_b3");

        // Forced blank on digit 0, decimal point on digit 2.
        wait_cyc(288);
        do_write(16'h1111, 4'b0001, 4'b0100, a);
        pin(323, 4'hF, 4'h1, 1'b1, "s5_blank0");
        pin(331, 4'hD, 4'h1, 1'b1, "s5_d1");
        pin(336, 4'hF, 4'h1, 1'b1, "s5_dead2");
        pin(339, 4'hB, 4'h1, 1'b0, "s5_dp2");
        pin(347, 4'h7, 4'h1, 1'b1, "s5_d3");

        // Reset mid-slot 2 with a write pending: pending data is discarded.
        wait_cyc(352);
        do_write(16'h9999, 4'h0, 4'h0, a);
        wait_cyc(372);
        chk("s6_pre_an", 16'(an), 16'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_an", 16'(an), 16'hF);
        chk("s6_rst_digit", 16'(digit), 16'h0);
        chk("s6_rst_dp", 16'(dp), 16'h1);
        chk("s6_rst_ft", 16'(frame_tick), 16'h0);
        chk("s6_rst_ready", 16'(wr_ready), 16'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pin(3, 4'hE, 4'h0, 1'b1, "s6_after");
        chk("s6_ready", 16'(wr_ready), 16'h1);
        pin(35, 4'hE, 4'h0, 1'b1, "s6_no_pend");
        pin(43, 4'hF, 4'h0, 1'b1, "s6_d1");

        // Random writes; the source holds its data while not accepted.
        for (int i = 0; i < 1500; i++) begin
            if (!(wr_valid && !last_acc)) begin
                wr_valid = ($urandom_range(0, 3) == 0);
                case ($urandom_range(0, 3))
                    0: wr_value = 16'($urandom);
                    1: wr_value = 16'($urandom) >> (4 * $urandom_range(1, 3));
                    2: wr_value = 16'h0;
                    default: wr_value = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
                endcase
                wr_blank = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                wr_dp    = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (80) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
